adc_oflow_detector: RTL and testbench
=====================================

ADC_OFLOW_DETECTOR -- requirements
Module: adc_oflow_detector

Interface
REQ-001 Parameter DATA_W, default 13: ADC sample width, two's complement.
REQ-002 Parameter CNT_W, default 4: width of run/hold length fields.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  detector enable; low forces idle.
REQ-006 adc_data  input  DATA_W  signed ADC sample.
REQ-007 adc_valid  input  1  qualifies adc_data this cycle.
REQ-008 sat_thresh  input  DATA_W  unsigned magnitude threshold.
REQ-009 run_len  input  CNT_W  consecutive saturated valid samples required to flag.
REQ-010 hold_len  input  CNT_W  extra cycles oflow_out is held after the last saturated sample.
REQ-011 oflow_out  output  1  overflow flag; drives the overflow latch's oflow_in.
REQ-012 oflow_events  output  8  count of FLAG entries, saturating.

Function
REQ-013 Stage 1 SHALL register sat_q = adc_valid & (|adc_data| >= sat_thresh) and vld_q = adc_valid; |x| is DATA_W-bit unsigned, so -2^(DATA_W-1) maps to 2^(DATA_W-1) without wrap.
REQ-014 FSM states SHALL be IDLE, ARMED, FLAG; state and counters update only from stage-1 registers.
REQ-015 IDLE: sat_q -> run_cnt=1; if effective run_len==1 go FLAG, else go ARMED.
REQ-016 ARMED: vld_q&sat_q increments run_cnt, reaching run_len -> FLAG; vld_q&!sat_q -> run_cnt=0, IDLE; !vld_q holds state and count.
REQ-017 run_len==0 SHALL be treated as 1.
REQ-018 FLAG entry SHALL load hold_cnt=hold_len; in FLAG, sat_q reloads hold_cnt; else hold_cnt==0 -> IDLE, otherwise decrement (decrements per clock, not per sample).
REQ-019 oflow_out SHALL be registered, high exactly while state==FLAG; it rises two rising edges after the edge sampling the completing sample; minimum pulse hold_len+1 cycles.
REQ-020 oflow_events SHALL increment by one on each transition into FLAG and stick at 255.
REQ-021 enable low SHALL force IDLE, clear run_cnt/hold_cnt and drop oflow_out on the next edge; oflow_events retained; stage 1 keeps running.
REQ-022 run_len/hold_len/sat_thresh changes mid-operation SHALL take effect at the next comparison/load; no restart needed.

Reset
REQ-023 rst_n low at a rising edge SHALL set state=IDLE, run_cnt=0, hold_cnt=0, sat_q=0, vld_q=0, oflow_out=0, oflow_events=0 (and peak_mag=0 when compiled in).
REQ-024 Reset mid-FLAG SHALL drop oflow_out on that edge with no partial pulse afterwards.

Configuration
REQ-025 Macro ADC_OFLOW_PEAK_EN SHALL, when defined, add input peak_clr (1) and output peak_mag (DATA_W): largest |adc_data| over valid samples since reset/peak_clr, registered, updated one cycle after the sample; peak_clr same-cycle with a sample loads that sample's magnitude.
REQ-026 Without ADC_OFLOW_PEAK_EN the ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Shared package font5_oflow_pkg SHALL hold the FSM state encoding (IDLE=2'd0, ARMED=2'd1, FLAG=2'd2) and the event counter width constant (8).
REQ-028 Sub-module adc_abs_compare (stage-1 magnitude + threshold compare, registered) SHALL be instantiated; FSM stays in the top.

Verification (DATA_W=13, sat_thresh=4000, run_len=3, hold_len=4 unless stated)
REQ-029 Samples 4000,-4001,4095 valid back-to-back then 100 -> oflow_out high for 5 cycles starting 2 edges after the 4095 sample; oflow_events=1.
REQ-030 Samples 4000,4000,100,4000,4000 -> oflow_out never asserts; oflow_events=0.
REQ-031 Sample -4096 with sat_thresh=4096, run_len=0 -> flag asserted (abs no wrap), pulse 5 cycles.
REQ-032 Saturated samples with adc_valid gaps (1,0,1,0,1) -> flag asserts; continuous saturation for 10 cycles keeps oflow_out high throughout, then 5 more cycles.
REQ-033 rst_n low or enable low during FLAG -> oflow_out 0 next edge; enable case keeps oflow_events; 300 flag events -> oflow_events=255.
REQ-034 With ADC_OFLOW_PEAK_EN: samples 10,-3000,200 -> peak_mag=3000; peak_clr with sample 50 -> peak_mag=50.

Source files
------------

// File: rtl/adc_oflow_detector_pkg.sv
// Shared definitions for the ADC overflow detector: FSM state encoding and event counter sizing.
package font5_oflow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FLAG  = 2'd2
    } oflow_state_e;

    localparam int EVT_W = 8;
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

endpackage

// File: rtl/adc_oflow_detector_if.sv
// Bus bundle between the ADC front end / control registers and the overflow detector.
// Optional peak tracking signals exist only when ADC_OFLOW_PEAK_EN is defined.
interface adc_oflow_detector_if #(
    parameter int DATA_W = 13,
    parameter int CNT_W  = 4
) ();
    import font5_oflow_pkg::*;

    logic              enable;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic [DATA_W-1:0] sat_thresh;
    logic [CNT_W-1:0]  run_len;
    logic [CNT_W-1:0]  hold_len;
    logic              oflow_out;
    logic [EVT_W-1:0]  oflow_events;
`ifdef ADC_OFLOW_PEAK_EN
    logic              peak_clr;
    logic [DATA_W-1:0] peak_mag;

    modport master (
        output enable, adc_data, adc_valid, sat_thresh, run_len, hold_len, peak_clr,
        input  oflow_out, oflow_events, peak_mag
    );

    modport slave (
        input  enable, adc_data, adc_valid, sat_thresh, run_len, hold_len, peak_clr,
        output oflow_out, oflow_events, peak_mag
    );
`else
    modport master (
        output enable, adc_data, adc_valid, sat_thresh, run_len, hold_len,
        input  oflow_out, oflow_events
    );

    modport slave (
        input  enable, adc_data, adc_valid, sat_thresh, run_len, hold_len,
        output oflow_out, oflow_events
    );
`endif

endinterface

// File: rtl/adc_oflow_detector_abs.sv
// Stage 1: sample magnitude and threshold compare, registered.
// With ADC_OFLOW_PEAK_EN defined it also tracks the peak magnitude of valid samples.
module adc_abs_compare #(
    parameter int DATA_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_thresh,
`ifdef ADC_OFLOW_PEAK_EN
    input  logic              i_peak_clr,
    output logic [DATA_W-1:0] o_peak_mag,
`endif
    output logic              o_sat_q,
    output logic              o_vld_q
);

    logic [DATA_W-1:0] w_mag;

    // Unsigned result, so the most negative code maps to 2^(DATA_W-1) instead of wrapping.
    always_comb begin
        w_mag = i_data[DATA_W-1] ? ((~i_data) + DATA_W'(1)) : i_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_sat_q <= 1'b0;
            o_vld_q <= 1'b0;
        end else begin
            o_sat_q <= i_valid && (w_mag >= i_thresh);
            o_vld_q <= i_valid;
        end
    end

`ifdef ADC_OFLOW_PEAK_EN
    logic [DATA_W-1:0] r_peakMag;

    // A clear coinciding with a valid sample restarts tracking from that sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_peakMag <= '0;
        end else if (i_peak_clr) begin
            r_peakMag <= i_valid ? w_mag : '0;
        end else if (i_valid && (w_mag > r_peakMag)) begin
            r_peakMag <= w_mag;
        end
    end

    assign o_peak_mag = r_peakMag;
`endif

endmodule

// File: rtl/adc_oflow_detector.sv
// ADC overflow detector: flags runs of saturated samples and stretches the flag by hold_len.
// Define ADC_OFLOW_PEAK_EN to add peak magnitude tracking (peak_clr / peak_mag).
module adc_oflow_detector
    import font5_oflow_pkg::*;
#(
    parameter int DATA_W = 13,
    parameter int CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adc_oflow_detector_if.slave  bus
);

    logic              w_satQ;
    logic              w_vldQ;
    logic [CNT_W-1:0]  w_runTarget;
    logic [CNT_W:0]    w_runNext;
    logic              w_runDone;

    oflow_state_e      r_state;
    logic [CNT_W-1:0]  r_runCnt;
    logic [CNT_W-1:0]  r_holdCnt;
    logic              r_oflow;
    logic [EVT_W-1:0]  r_events;

    adc_abs_compare #(
        .DATA_W (DATA_W)
    ) u_abs (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (bus.adc_data),
        .i_valid    (bus.adc_valid),
        .i_thresh   (bus.sat_thresh),
`ifdef ADC_OFLOW_PEAK_EN
        .i_peak_clr (bus.peak_clr),
        .o_peak_mag (bus.peak_mag),
`endif
        .o_sat_q    (w_satQ),
        .o_vld_q    (w_vldQ)
    );

    // A zero run length behaves as one; >= lets a lowered run_len take effect mid-run.
    always_comb begin
        w_runTarget = (bus.run_len == '0) ? CNT_W'(1) : bus.run_len;
        w_runNext   = {1'b0, r_runCnt} + (CNT_W+1)'(1);
        w_runDone   = (w_runNext >= {1'b0, w_runTarget});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_runCnt  <= '0;
            r_holdCnt <= '0;
            r_oflow   <= 1'b0;
            r_events  <= '0;
        end else if (!bus.enable) begin
            r_state   <= IDLE;
            r_runCnt  <= '0;
            r_holdCnt <= '0;
            r_oflow   <= 1'b0;
        end else begin
            r_oflow <= (r_state == FLAG);
            case (r_state)
                IDLE: begin
                    if (w_satQ) begin
                        r_runCnt <= CNT_W'(1);
                        if (w_runTarget == CNT_W'(1)) begin
                            r_state   <= FLAG;
                            r_holdCnt <= bus.hold_len;
                            if (r_events != EVT_MAX) r_events <= r_events + EVT_W'(1);
                        end else begin
                            r_state <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (w_vldQ && w_satQ) begin
                        r_runCnt <= w_runNext[CNT_W-1:0];
                        if (w_runDone) begin
                            r_state   <= FLAG;
                            r_holdCnt <= bus.hold_len;
                            if (r_events != EVT_MAX) r_events <= r_events + EVT_W'(1);
                        end
                    end else if (w_vldQ) begin
                        r_runCnt <= '0;
                        r_state  <= IDLE;
                    end
                end
                FLAG: begin
                    // Hold counts clocks, not samples, once saturation stops.
                    if (w_satQ) begin
                        r_holdCnt <= bus.hold_len;
                    end else if (r_holdCnt == '0) begin
                        r_state  <= IDLE;
                        r_runCnt <= '0;
                    end else begin
                        r_holdCnt <= r_holdCnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_runCnt  <= '0;
                    r_holdCnt <= '0;
                end
            endcase
        end
    end

    assign bus.oflow_out    = r_oflow;
    assign bus.oflow_events = r_events;

endmodule

// File: tb/tb_adc_oflow_detector.sv
// Directed bench for adc_oflow_detector: per-cycle oflow_out expectations go through a scoreboard queue.
// Peak tracking checks are included when ADC_OFLOW_PEAK_EN is defined.
module tb_adc_oflow_detector;
    import font5_oflow_pkg::*;

    localparam int DW = 13;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    adc_oflow_detector_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    adc_oflow_detector #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    total = 0;
    int    bad   = 0;
    int    stepNo = 0;
    string phase = "init";
    logic  expQ[$];

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
        total++;
        assert (obs === expVal) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expVal);
        end
    endtask

    // Pops the expectation queued when this cycle's stimulus was driven.
    task automatic checkOutput();
        logic expOflow;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $error("[TB] FAIL %s#%0d oflow_out observed=%0b expected=<empty scoreboard>", phase, stepNo, bus.oflow_out);
        end else begin
            expOflow = expQ.pop_front();
            assert (bus.oflow_out === expOflow) else begin
                bad++;
                $error("[TB] FAIL %s#%0d oflow_out observed=%0b expected=%0b", phase, stepNo, bus.oflow_out, expOflow);
            end
        end
    endtask

    task automatic driveOnly(input int data, input logic valid);
        bus.adc_data  = DW'(data);
        bus.adc_valid = valid;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int data, input logic valid, input logic expOflow);
        stepNo++;
        expQ.push_back(expOflow);
        driveOnly(data, valid);
        checkOutput();
    endtask

    task automatic doReset();
        phase  = "reset";
        rst_n  = 1'b0;
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        checkValue("reset_events", 32'(bus.oflow_events), 32'd0);
`ifdef ADC_OFLOW_PEAK_EN
        checkValue("reset_peak", 32'(bus.peak_mag), 32'd0);
`endif
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.enable     = 1'b1;
        bus.adc_data   = '0;
        bus.adc_valid  = 1'b0;
        bus.sat_thresh = 13'd4000;
        bus.run_len    = 4'd3;
        bus.hold_len   = 4'd4;
`ifdef ADC_OFLOW_PEAK_EN
        bus.peak_clr   = 1'b0;
`endif
        doReset();

        // Three saturated samples: pulse of hold_len+1 starting two edges after the last one.
        phase = "run3"; stepNo = 0;
        applyStimulus( 4000, 1'b1, 1'b0);
        applyStimulus(-4001, 1'b1, 1'b0);
        applyStimulus( 4095, 1'b1, 1'b0);
        applyStimulus(  100, 1'b1, 1'b0);
        repeat (5) applyStimulus(0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 1'b0);
        checkValue("run3_events", 32'(bus.oflow_events), 32'd1);

        // Just below threshold never flags, even with a run length of one.
        phase = "below"; stepNo = 0;
        bus.run_len = 4'd1;
        applyStimulus( 3999, 1'b1, 1'b0);
        applyStimulus(-3999, 1'b1, 1'b0);
        repeat (3) applyStimulus(0, 1'b0, 1'b0);
        checkValue("below_events", 32'(bus.oflow_events), 32'd1);

        // A non-saturated valid sample breaks the run.
        doReset();
        phase = "broken"; stepNo = 0;
        bus.run_len = 4'd3;
        applyStimulus(4000, 1'b1, 1'b0);
        applyStimulus(4000, 1'b1, 1'b0);
        applyStimulus( 100, 1'b1, 1'b0);
        applyStimulus(4000, 1'b1, 1'b0);
        applyStimulus(4000, 1'b1, 1'b0);
        repeat (4) applyStimulus(0, 1'b0, 1'b0);
        checkValue("broken_events", 32'(bus.oflow_events), 32'd0);

        // Most negative code must not wrap; run_len of zero acts as one.
        doReset();
        phase = "negfull"; stepNo = 0;
        bus.sat_thresh = 13'd4096;
        bus.run_len    = 4'd0;
        applyStimulus(-4095, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(-4096, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        repeat (5) applyStimulus(0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 1'b0);
        checkValue("negfull_events", 32'(bus.oflow_events), 32'd1);

        // Valid gaps do not break the run; continuous saturation keeps reloading the hold.
        doReset();
        phase = "gaps"; stepNo = 0;
        bus.sat_thresh = 13'd4000;
        bus.run_len    = 4'd3;
        applyStimulus( 4000, 1'b1, 1'b0);
        applyStimulus( 4000, 1'b0, 1'b0);
        applyStimulus( 4000, 1'b1, 1'b0);
        applyStimulus(-4000, 1'b0, 1'b0);
        applyStimulus( 4050, 1'b1, 1'b0);
        applyStimulus( 4000, 1'b1, 1'b0);
        repeat (9) applyStimulus(4000, 1'b1, 1'b1);
        repeat (6) applyStimulus(0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 1'b0);
        checkValue("gaps_events", 32'(bus.oflow_events), 32'd1);

        // Enable low inside FLAG drops the flag next edge and keeps the event count.
        doReset();
        phase = "enable"; stepNo = 0;
        bus.run_len = 4'd1;
        applyStimulus(4000, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1);
        bus.enable = 1'b0;
        applyStimulus(0, 1'b0, 1'b0);
        checkValue("enable_events_low", 32'(bus.oflow_events), 32'd1);
        bus.enable = 1'b1;
        repeat (3) applyStimulus(0, 1'b0, 1'b0);
        checkValue("enable_events_after", 32'(bus.oflow_events), 32'd1);

        // Reset inside FLAG drops the flag on that edge with no tail afterwards.
        phase = "rstflag"; stepNo = 0;
        applyStimulus(4000, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1);
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0);
        checkValue("rstflag_events", 32'(bus.oflow_events), 32'd0);
        rst_n = 1'b1;
        repeat (4) applyStimulus(0, 1'b0, 1'b0);

        // Event counter saturates at 255.
        doReset();
        phase = "evtsat"; stepNo = 0;
        bus.run_len  = 4'd1;
        bus.hold_len = 4'd0;
        for (int i = 0; i < 254; i++) begin
            driveOnly(4000, 1'b1);
            driveOnly(0, 1'b0);
        end
        driveOnly(0, 1'b0);
        driveOnly(0, 1'b0);
        checkValue("evtsat_254", 32'(bus.oflow_events), 32'd254);
        for (int i = 0; i < 46; i++) begin
            driveOnly(4000, 1'b1);
            driveOnly(0, 1'b0);
        end
        driveOnly(0, 1'b0);
        driveOnly(0, 1'b0);
        checkValue("evtsat_300", 32'(bus.oflow_events), 32'd255);

`ifdef ADC_OFLOW_PEAK_EN
        doReset();
        phase = "peak"; stepNo = 0;
        bus.hold_len = 4'd4;
        applyStimulus(   10, 1'b1, 1'b0);
        checkValue("peak_first", 32'(bus.peak_mag), 32'd10);
        applyStimulus(-3000, 1'b1, 1'b0);
        applyStimulus(  200, 1'b1, 1'b0);
        checkValue("peak_max", 32'(bus.peak_mag), 32'd3000);
        bus.peak_clr = 1'b1;
        applyStimulus(   50, 1'b1, 1'b0);
        bus.peak_clr = 1'b0;
        checkValue("peak_clr", 32'(bus.peak_mag), 32'd50);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
